// File: rtl/display_driver_scan_controller.sv
// display_driver_scan_controller: BCM row-scan sequencer that overlaps loading of the next slot with display of the current one
module display_driver_scan_controller #(
    parameter int rows      = 16,
    parameter int bitwidth  = 8,
    parameter int base_time = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        load,
    input  logic                        complete,
    output logic [$clog2(rows)-1:0]     load_row,
    output logic [$clog2(bitwidth)-1:0] load_plane,
    output logic [$clog2(rows)-1:0]     row_addr,
    output logic                        lat,
    output logic                        blank,
    output logic                        frame_done
);
    localparam int pw = $clog2(bitwidth);
    localparam int tw = $clog2((base_time << (bitwidth - 1)) + 1);
    localparam logic [pw-1:0] plane_max = pw'(bitwidth - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, LATCH} state_t;

    state_t        state, state_nx;
    logic [tw-1:0] timer;
    logic          last_plane;

    assign last_plane = load_plane == plane_max;
    assign blank      = timer == '0;
    assign frame_done = lat && (&load_row) && last_plane;

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // Next state and loader/latch strobes; an enable drop only takes effect once the panel is dark in WAIT
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        lat      = 1'b0;
        case (state)
            IDLE:    state_nx = enable ? LOAD : IDLE;
            LOAD: begin
                load     = 1'b1;
                state_nx = complete ? WAIT : LOAD;
            end
            WAIT:    state_nx = blank ? (enable ? LATCH : IDLE) : WAIT;
            LATCH: begin
                lat      = 1'b1;
                state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Display timer: reloaded with the BCM weight of the slot being latched, then counts down to dark
    always_ff @(posedge clk or negedge rst)
        if (!rst)              timer <= '0;
        else if (lat)          timer <= tw'(base_time) << load_plane;
        else if (timer != '0)  timer <= timer - tw'(1);

    // Slot pointer: plane is the inner index, row the outer; rows is a power of two so the row wraps naturally
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            load_row   <= '0;
            load_plane <= '0;
        end else if (lat) begin
            load_plane <= last_plane ? '0 : load_plane + pw'(1);
            if (last_plane) load_row <= load_row + 1'b1;
        end

    // Panel row address switches on entry to LATCH so it is already valid during the strobe
    always_ff @(posedge clk or negedge rst)
        if (!rst)                                 row_addr <= '0;
        else if (state == WAIT && state_nx == LATCH) row_addr <= load_row;
endmodule

// File: tb/tb_display_driver_scan_controller.sv
// tb_display_driver_scan_controller: randomized loader stimulus with a queue scoreboard checked at every latch strobe
module tb_display_driver_scan_controller;
    localparam int rows = 4, bitwidth = 2, base_time = 3;
    localparam int slots = rows * bitwidth;

    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, complete = 1'b0;
    logic       load, lat, blank, frame_done;
    logic [1:0] load_row, row_addr;
    logic [0:0] load_plane;
    logic [8:0] outv;

    typedef struct {int row; int plane; bit fd; int w;} exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int nlat = 0, cyc = 0, t_dark = 0;
    int dly_min = 0, dly_max = 0;
    int n0;

    assign outv = {load, lat, blank, frame_done, row_addr, load_row, load_plane};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_driver_scan_controller #(.rows(rows), .bitwidth(bitwidth), .base_time(base_time)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .complete(complete),
        .load_row(load_row), .load_plane(load_plane), .row_addr(row_addr),
        .lat(lat), .blank(blank), .frame_done(frame_done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_lats(input int n, input int budget);
        int target = nlat + n;
        int c = 0;
        while (nlat < target && c < budget) begin
            tick();
            c++;
        end
        check("run_progress", int'(nlat >= target), 1);
    endtask

    task automatic wait_load(input int budget);
        int c = 0;
        while (!load && c < budget) begin
            tick();
            c++;
        end
        check("load_seen", int'(load), 1);
    endtask

    // Row loader model: checks which slot is requested, answers after a random delay, then queues the expected latch
    initial begin
        int slot, d;
        forever begin
            tick();
            if (rst && load) begin
                slot = nlat % slots;
                check("load_row", int'(load_row), slot / bitwidth);
                check("load_plane", int'(load_plane), slot % bitwidth);
                d = $urandom_range(dly_max, dly_min);
                repeat (d) tick();
                if (rst) check("load_held", int'(load), 1);
                complete = 1'b1;
                tick();
                complete = 1'b0;
                sb.push_back('{slot / bitwidth, slot % bitwidth, slot == slots - 1, cyc});
            end
        end
    end

    // Monitor: every latch strobe pops one expectation and checks address, frame pulse, timing and lit duration
    initial begin
        exp_t e;
        int n, m;
        forever begin
            tick();
            if (rst && !lat) check("fd_stray", int'(frame_done), 0);
            if (rst && lat) begin
                check("lat_blank", int'(blank), 1);
                if (sb.size() == 0) begin
                    check("sb_nonempty", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("row_addr", int'(row_addr), e.row);
                    check("frame_done", int'(frame_done), int'(e.fd));
                    m = e.w > t_dark ? e.w : t_dark;
                    check("lat_latency", cyc, m + 1);
                    nlat++;
                    n = 0;
                    tick();
                    check("load_after_lat", int'(load), 1);
                    while (!blank && n < 1000) begin
                        n++;
                        tick();
                    end
                    t_dark = cyc;
                    check("unblank_len", n, base_time << e.plane);
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("rst_load", int'(load), 0);
        check("rst_blank", int'(blank), 1);
        check("rst_lat", int'(lat), 0);
        check("rst_row_addr", int'(row_addr), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_load_row", int'(load_row), 0);
        check("rst_load_plane", int'(load_plane), 0);
        enable = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (20) begin
            tick();
            check("idle_static", int'(outv), 'h40);
        end
        dly_min = 4; dly_max = 4;
        enable = 1'b1;
        run_lats(1, 100);
        dly_min = 0; dly_max = 2;
        run_lats(1, 100);
        dly_min = 13; dly_max = 13;
        run_lats(2, 200);
        dly_min = 0; dly_max = 12;
        run_lats(24, 2000);
        dly_min = 8; dly_max = 8;
        wait_load(100);
        enable = 1'b0;
        n0 = nlat;
        repeat (60) tick();
        check("idle_load", int'(load), 0);
        check("idle_blank", int'(blank), 1);
        check("no_lat", nlat, n0);
        check("discard_sb", sb.size(), 1);
        sb.delete();
        enable = 1'b1;
        dly_min = 0; dly_max = 12;
        run_lats(6, 500);
        dly_min = 10; dly_max = 10;
        wait_load(100);
        repeat (8) tick();
        check("pre_rst_load", int'(load), 1);
        rst = 1'b0;
        nlat = 0;
        #1;
        check("rst_mid_load", int'(load), 0);
        check("rst_mid_blank", int'(blank), 1);
        enable = 1'b0;
        repeat (15) tick();
        sb.delete();
        @(negedge clk) rst = 1'b1;
        tick();
        check("post_rst_load_row", int'(load_row), 0);
        check("post_rst_row_addr", int'(row_addr), 0);
        dly_min = 0; dly_max = 12;
        enable = 1'b1;
        run_lats(4, 400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
